// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin sharing of the 8 bidirectional uio pins between two requesters,
// with a turnaround gap between owners. Optional hold limit: define UIO_ARB_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module uio_bus_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] oe0,
  input  logic [7:0] oe1,
  input  logic [7:0] uio_in,
  output logic [1:0] gnt,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       timeout
);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn_cycles
    $error("uio_bus_arbiter: TURN_CYCLES must be 1..15");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("uio_bus_arbiter: MAX_HOLD must be 2..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t     state;
  logic       own;
  logic       last;
  logic [3:0] turn_cnt;
  logic       win;
  logic       start;
  logic       force_rel;

  // On a tie the requester that did not own the bus last time wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end

  assign start = ena && (req != 2'b00) &&
                 ((state == IDLE) || ((state == TURN) && (turn_cnt == 4'd0)));

`ifdef UIO_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign force_rel = (hold_cnt == 8'(MAX_HOLD - 1)) && req[~own];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (start) begin
      hold_cnt <= 8'd0;
    end else if (state == GRANT && hold_cnt != 8'hFF) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      own      <= 1'b0;
      last     <= 1'b1;
      turn_cnt <= 4'd0;
      gnt      <= 2'b00;
      uio_out  <= 8'h00;
      uio_oe   <= 8'h00;
      rd_data  <= 8'h00;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      rd_data <= uio_in & ~uio_oe;
      timeout <= 1'b0;

      case (state)
        GRANT: begin
          if (!ena || !req[own] || force_rel) begin
            state    <= TURN;
            gnt      <= 2'b00;
            uio_out  <= 8'h00;
            uio_oe   <= 8'h00;
            turn_cnt <= 4'(TURN_CYCLES - 1);
            // A normal release or an enable drop on the same edge masks the forced-release pulse.
            timeout  <= force_rel && ena && req[own];
          end else begin
            uio_out <= own ? data1 : data0;
            uio_oe  <= own ? oe1 : oe0;
          end
        end
        TURN: begin
          if (turn_cnt != 4'd0) begin
            turn_cnt <= turn_cnt - 4'd1;
          end else if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase

      if (start) begin
        state   <= GRANT;
        own     <= win;
        last    <= win;
        gnt     <= win ? 2'b10 : 2'b01;
        uio_out <= win ? data1 : data0;
        uio_oe  <= win ? oe1 : oe0;
        busy    <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
// Directed self-checking bench for uio_bus_arbiter (TURN_CYCLES = 2, MAX_HOLD = 4).
`default_nettype none

module tb_uio_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] data0 = 8'h00, data1 = 8'h00, oe0 = 8'h00, oe1 = 8'h00, uio_in = 8'h00;
  logic [1:0] gnt;
  logic [7:0] uio_out, uio_oe, rd_data;
  logic       busy, timeout;

  int n_cmp = 0;
  int n_err = 0;

  uio_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
    .data0(data0), .data1(data1), .oe0(oe0), .oe1(oe1), .uio_in(uio_in),
    .gnt(gnt), .uio_out(uio_out), .uio_oe(uio_oe), .rd_data(rd_data),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; req = 2'b00;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    n_cmp++; if (uio_out !== 8'h00) begin n_err++; $display("FAIL reset_out got %h exp 00", uio_out); end
    n_cmp++; if (uio_oe !== 8'h00) begin n_err++; $display("FAIL reset_oe got %h exp 00", uio_oe); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd got %h exp 00", rd_data); end
    n_cmp++; if ({busy, timeout} !== 2'b00) begin n_err++; $display("FAIL reset_busy_to got %b exp 00", {busy, timeout}); end
  endtask

  task automatic test_single_grant();
    data0 = 8'hA5; oe0 = 8'hFF; req = 2'b01;
    step();
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL grant_gnt got %b exp 01", gnt); end
    n_cmp++; if (uio_out !== 8'hA5) begin n_err++; $display("FAIL grant_out got %h exp a5", uio_out); end
    n_cmp++; if (uio_oe !== 8'hFF) begin n_err++; $display("FAIL grant_oe got %h exp ff", uio_oe); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL grant_busy got %b exp 1", busy); end
    data0 = 8'h3C; oe0 = 8'h7E;
    step();
    n_cmp++; if ({uio_out, uio_oe} !== 16'h3C7E) begin n_err++; $display("FAIL grant_reload got %h exp 3c7e", {uio_out, uio_oe}); end
  endtask

  task automatic test_handover();
    data1 = 8'h5A; oe1 = 8'h0F; req = 2'b11;
    step();
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL hand_keep got %b exp 01", gnt); end
    req = 2'b10;
    step();
    n_cmp++; if ({gnt, uio_oe, uio_out} !== 18'h0) begin n_err++; $display("FAIL hand_gap1 got %h exp 0", {gnt, uio_oe, uio_out}); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hand_busy_turn got %b exp 1", busy); end
    step();
    n_cmp++; if ({gnt, uio_oe} !== 10'h0) begin n_err++; $display("FAIL hand_gap2 got %h exp 0", {gnt, uio_oe}); end
    step();
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL hand_gnt1 got %b exp 10", gnt); end
    n_cmp++; if ({uio_out, uio_oe} !== 16'h5A0F) begin n_err++; $display("FAIL hand_data1 got %h exp 5a0f", {uio_out, uio_oe}); end
    req = 2'b00;
    step(); step(); step();
    n_cmp++; if ({busy, gnt} !== 3'b000) begin n_err++; $display("FAIL hand_idle got %b exp 000", {busy, gnt}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 2'b11;
    step();
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rr_first got %b exp 01", gnt); end
    req = 2'b00;
    step(); step(); step();
    req = 2'b11;
    step();
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rr_second got %b exp 10", gnt); end
    req = 2'b00;
    step(); step(); step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 2'b11;
    step();
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL to_start got %b exp 01", gnt); end
    for (int i = 1; i < 4; i++) begin
      step();
      n_cmp++; if ({gnt, timeout} !== 3'b010) begin n_err++; $display("FAIL to_hold%0d got %b exp 010", i, {gnt, timeout}); end
    end
    step();
`ifdef UIO_ARB_TIMEOUT_EN
    n_cmp++; if ({gnt, timeout} !== 3'b001) begin n_err++; $display("FAIL to_pulse got %b exp 001", {gnt, timeout}); end
    step();
    n_cmp++; if ({gnt, timeout} !== 3'b000) begin n_err++; $display("FAIL to_gap got %b exp 000", {gnt, timeout}); end
    step();
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL to_next got %b exp 10", gnt); end
`else
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({gnt, timeout} !== 3'b010) begin n_err++; $display("FAIL to_persist%0d got %b exp 010", i, {gnt, timeout}); end
      step();
    end
`endif
    req = 2'b00;
    step(); step(); step();
  endtask

  task automatic test_ena();
    do_reset();
    req = 2'b01; oe0 = 8'hFF;
    step();
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL ena_grant got %b exp 01", gnt); end
    ena = 1'b0;
    step();
    n_cmp++; if ({gnt, uio_oe} !== 10'h0) begin n_err++; $display("FAIL ena_release got %h exp 0", {gnt, uio_oe}); end
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({gnt, uio_oe} !== 10'h0) begin n_err++; $display("FAIL ena_block%0d got %h exp 0", i, {gnt, uio_oe}); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ena_idle got %b exp 0", busy); end
    ena = 1'b1;
    step();
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL ena_resume got %b exp 10", gnt); end
    req = 2'b00;
    step(); step(); step();
  endtask

  task automatic test_rd_data_and_async_reset();
    do_reset();
    req = 2'b01; data0 = 8'h00; oe0 = 8'hF0; uio_in = 8'hFF;
    step();
    n_cmp++; if (uio_oe !== 8'hF0) begin n_err++; $display("FAIL rd_oe got %h exp f0", uio_oe); end
    step();
    n_cmp++; if (rd_data !== 8'h0F) begin n_err++; $display("FAIL rd_mask got %h exp 0f", rd_data); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({gnt, uio_oe} !== 10'h0) begin n_err++; $display("FAIL async_rst got %h exp 0", {gnt, uio_oe}); end
    req = 2'b00;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_handover();
    test_round_robin();
    test_timeout();
    test_ena();
    test_rd_data_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
